// File: rtl/am_query_scheduler_pkg.sv
// Shared widths, scheduler state encoding and the ceilLog2 helper
// for the associative-memory query scheduler.
package am_query_scheduler_pkg;

    localparam int HV_DIMENSION   = 32;
    localparam int LABEL_WIDTH    = 4;
    localparam int DISTANCE_WIDTH = 8;

    typedef enum logic [1:0] {
        SCHED_ARB   = 2'd0,
        SCHED_ISSUE = 2'd1,
        SCHED_WAIT  = 2'd2,
        SCHED_RESP  = 2'd3
    } schedState_t;

    function automatic int ceilLog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/am_query_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or above
// the pointer, wrapping modulo NUM_REQ.
module am_query_scheduler_rr_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  Req_SI,
    input  logic [ID_WIDTH-1:0] Pointer_DI,
    output logic [NUM_REQ-1:0]  Grant_SO,
    output logic [ID_WIDTH-1:0] GrantId_DO,
    output logic                AnyValid_SO
);

    localparam logic [ID_WIDTH:0] NUM_REQ_W = (ID_WIDTH+1)'(NUM_REQ);

    logic [ID_WIDTH:0]   sum;
    logic [ID_WIDTH-1:0] idx;
    logic                found;

    always_comb begin
        Grant_SO   = '0;
        GrantId_DO = '0;
        found      = 1'b0;
        sum        = '0;
        idx        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, Pointer_DI} + (ID_WIDTH+1)'(k);
            if (sum >= NUM_REQ_W) begin
                sum = sum - NUM_REQ_W;
            end
            idx = sum[ID_WIDTH-1:0];
            if (!found && Req_SI[idx]) begin
                found         = 1'b1;
                Grant_SO[idx] = 1'b1;
                GrantId_DO    = idx;
            end
        end
        AnyValid_SO = found;
    end

endmodule

// File: rtl/am_query_scheduler.sv
// Round-robin scheduler sharing one associative memory between requesters.
// Optional AM watchdog: define AM_QUERY_SCHEDULER_TIMEOUT_EN.
module am_query_scheduler
    import am_query_scheduler_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int ID_WIDTH       = ceilLog2(NUM_REQ),
    parameter int HV_DIM         = HV_DIMENSION,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        Clk_CI,
    input  logic                        Reset_RBI,
    input  logic [NUM_REQ-1:0]          ReqValid_SI,
    output logic [NUM_REQ-1:0]          ReqReady_SO,
    input  logic [NUM_REQ*HV_DIM-1:0]   ReqHypervector_DI,
    output logic                        AmValid_SO,
    input  logic                        AmReady_SI,
    output logic [HV_DIM-1:0]           AmHypervector_DO,
    input  logic                        AmValid_SI,
    output logic                        AmReady_SO,
    input  logic [LABEL_WIDTH-1:0]      AmLabel_A_DI,
    input  logic [LABEL_WIDTH-1:0]      AmLabel_V_DI,
    input  logic [DISTANCE_WIDTH-1:0]   AmDistance_A_DI,
    input  logic [DISTANCE_WIDTH-1:0]   AmDistance_V_DI,
`ifdef AM_QUERY_SCHEDULER_TIMEOUT_EN
    output logic                        RspTimeout_SO,
`endif
    output logic                        RspValid_SO,
    input  logic                        RspReady_SI,
    output logic [ID_WIDTH-1:0]         RspId_DO,
    output logic [LABEL_WIDTH-1:0]      RspLabel_A_DO,
    output logic [LABEL_WIDTH-1:0]      RspLabel_V_DO,
    output logic [DISTANCE_WIDTH-1:0]   RspDistance_A_DO,
    output logic [DISTANCE_WIDTH-1:0]   RspDistance_V_DO
);

    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

    schedState_t         state_SP;
    logic [ID_WIDTH-1:0] pointer_DP;
    logic [HV_DIM-1:0]   query_DP;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_WIDTH-1:0] grantId;
    logic                anyValid;
    logic                drain_SP;

`ifdef AM_QUERY_SCHEDULER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] count_DP;
`endif

    am_query_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_WIDTH(ID_WIDTH)
    ) i_arb (
        .Req_SI     (ReqValid_SI),
        .Pointer_DI (pointer_DP),
        .Grant_SO   (grant),
        .GrantId_DO (grantId),
        .AnyValid_SO(anyValid)
    );

    // Reset gates the grant so no ready leaks while reset is held.
    assign ReqReady_SO = (state_SP == SCHED_ARB && Reset_RBI) ? grant : '0;
    assign AmValid_SO  = (state_SP == SCHED_ISSUE);
    assign AmReady_SO  = (state_SP == SCHED_WAIT) && !drain_SP;
    assign RspValid_SO = (state_SP == SCHED_RESP);
    assign AmHypervector_DO = query_DP;

    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            state_SP         <= SCHED_ARB;
            pointer_DP       <= '0;
            query_DP         <= '0;
            RspId_DO         <= '0;
            RspLabel_A_DO    <= '0;
            RspLabel_V_DO    <= '0;
            RspDistance_A_DO <= '0;
            RspDistance_V_DO <= '0;
            drain_SP         <= 1'b0;
`ifdef AM_QUERY_SCHEDULER_TIMEOUT_EN
            count_DP         <= '0;
            RspTimeout_SO    <= 1'b0;
`endif
        end else begin
            if (drain_SP && !AmValid_SI) begin
                drain_SP <= 1'b0;
            end
            unique case (state_SP)
                SCHED_ARB: begin
                    if (anyValid) begin
                        query_DP <= ReqHypervector_DI[int'(grantId)*HV_DIM +: HV_DIM];
                        RspId_DO <= grantId;
                        state_SP <= SCHED_ISSUE;
                    end
                end
                SCHED_ISSUE: begin
                    if (AmReady_SI) begin
`ifdef AM_QUERY_SCHEDULER_TIMEOUT_EN
                        count_DP <= '0;
`endif
                        state_SP <= SCHED_WAIT;
                    end
                end
                SCHED_WAIT: begin
                    if (AmValid_SI && !drain_SP) begin
                        RspLabel_A_DO    <= AmLabel_A_DI;
                        RspLabel_V_DO    <= AmLabel_V_DI;
                        RspDistance_A_DO <= AmDistance_A_DI;
                        RspDistance_V_DO <= AmDistance_V_DI;
`ifdef AM_QUERY_SCHEDULER_TIMEOUT_EN
                        RspTimeout_SO    <= 1'b0;
`endif
                        state_SP <= SCHED_RESP;
                    end
`ifdef AM_QUERY_SCHEDULER_TIMEOUT_EN
                    else if (count_DP == CNT_W'(TIMEOUT_CYCLES)) begin
                        RspLabel_A_DO    <= '0;
                        RspLabel_V_DO    <= '0;
                        RspDistance_A_DO <= '0;
                        RspDistance_V_DO <= '0;
                        RspTimeout_SO    <= 1'b1;
                        drain_SP         <= 1'b1;
                        state_SP         <= SCHED_RESP;
                    end else begin
                        count_DP <= count_DP + 1'b1;
                    end
`endif
                end
                SCHED_RESP: begin
                    if (RspReady_SI) begin
                        pointer_DP <= (RspId_DO == LAST_ID) ? '0 : RspId_DO + 1'b1;
                        state_SP   <= SCHED_ARB;
                    end
                end
                default: state_SP <= SCHED_ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_am_query_scheduler.sv
// Randomized self-checking bench for am_query_scheduler with a
// behavioural round-robin model and a scripted AM responder.
module tb_am_query_scheduler;
    import am_query_scheduler_pkg::*;

    localparam int NR  = 3;
    localparam int IDW = 2;
    localparam int HV  = HV_DIMENSION;
    localparam int LW  = LABEL_WIDTH;
    localparam int DW  = DISTANCE_WIDTH;

    logic              Clk_CI = 1'b0;
    logic              Reset_RBI;
    logic [NR-1:0]     ReqValid_SI;
    logic [NR-1:0]     ReqReady_SO;
    logic [NR*HV-1:0]  ReqHypervector_DI;
    logic              AmValid_SO;
    logic              AmReady_SI;
    logic [HV-1:0]     AmHypervector_DO;
    logic              AmValid_SI;
    logic              AmReady_SO;
    logic [LW-1:0]     AmLabel_A_DI, AmLabel_V_DI;
    logic [DW-1:0]     AmDistance_A_DI, AmDistance_V_DI;
    logic              RspValid_SO;
    logic              RspReady_SI;
    logic [IDW-1:0]    RspId_DO;
    logic [LW-1:0]     RspLabel_A_DO, RspLabel_V_DO;
    logic [DW-1:0]     RspDistance_A_DO, RspDistance_V_DO;
`ifdef AM_QUERY_SCHEDULER_TIMEOUT_EN
    logic              RspTimeout_SO;
`endif

    int nCmp = 0;
    int nBad = 0;
    int modelPtr = 0;

    always #5 Clk_CI = ~Clk_CI;

    am_query_scheduler #(
        .NUM_REQ(NR),
        .HV_DIM(HV),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .Clk_CI(Clk_CI),
        .Reset_RBI(Reset_RBI),
        .ReqValid_SI(ReqValid_SI),
        .ReqReady_SO(ReqReady_SO),
        .ReqHypervector_DI(ReqHypervector_DI),
        .AmValid_SO(AmValid_SO),
        .AmReady_SI(AmReady_SI),
        .AmHypervector_DO(AmHypervector_DO),
        .AmValid_SI(AmValid_SI),
        .AmReady_SO(AmReady_SO),
        .AmLabel_A_DI(AmLabel_A_DI),
        .AmLabel_V_DI(AmLabel_V_DI),
        .AmDistance_A_DI(AmDistance_A_DI),
        .AmDistance_V_DI(AmDistance_V_DI),
`ifdef AM_QUERY_SCHEDULER_TIMEOUT_EN
        .RspTimeout_SO(RspTimeout_SO),
`endif
        .RspValid_SO(RspValid_SO),
        .RspReady_SI(RspReady_SI),
        .RspId_DO(RspId_DO),
        .RspLabel_A_DO(RspLabel_A_DO),
        .RspLabel_V_DO(RspLabel_V_DO),
        .RspDistance_A_DO(RspDistance_A_DO),
        .RspDistance_V_DO(RspDistance_V_DO)
    );

    // Model: first valid index scanning upward from the pointer, wrapping.
    function automatic int expGrant(input logic [NR-1:0] m, input int p);
        for (int k = 0; k < NR; k++) begin
            if (m[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR*HV-1:0] rndHvs();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic randomizeAmBus();
        AmLabel_A_DI    = LW'($urandom);
        AmLabel_V_DI    = LW'($urandom);
        AmDistance_A_DI = DW'($urandom);
        AmDistance_V_DI = DW'($urandom);
    endtask

    // Drives one full query; returns what the DUT presented.
    task automatic runQuery(
        input  logic [NR-1:0]    vmask,
        input  logic [NR*HV-1:0] hvs,
        input  int               issueStall,
        input  int               amDelay,
        input  int               rspStall,
        input  logic [LW-1:0]    la, lv,
        input  logic [DW-1:0]    da, dv,
        output int               gotId,
        output logic [NR-1:0]    readyObs,
        output logic [HV-1:0]    hvObs,
        output logic [LW-1:0]    ola, olv,
        output logic [DW-1:0]    oda, odv,
        output int               bad
    );
        int n;
        bad = 0; gotId = -1; readyObs = '0; hvObs = '0;
        ola = '0; olv = '0; oda = '0; odv = '0;
        @(negedge Clk_CI);
        ReqValid_SI = vmask;
        ReqHypervector_DI = hvs;
        #1;
        n = 0;
        while (ReqReady_SO == '0 && n < 20) begin
            @(negedge Clk_CI); #1; n++;
        end
        if (ReqReady_SO == '0) begin
            bad = 1000;
            ReqValid_SI = '0;
            return;
        end
        readyObs = ReqReady_SO;
        @(negedge Clk_CI);
        ReqValid_SI = '1;
        ReqHypervector_DI = rndHvs();
        #1;
        if (AmValid_SO !== 1'b1 || AmReady_SO !== 1'b0) bad++;
        hvObs = AmHypervector_DO;
        AmValid_SI = 1'b1;
        randomizeAmBus();
        repeat (issueStall) begin
            @(negedge Clk_CI); #1;
            if (AmValid_SO !== 1'b1 || AmHypervector_DO !== hvObs) bad++;
            if (ReqReady_SO !== '0 || RspValid_SO !== 1'b0) bad++;
        end
        AmValid_SI = 1'b0;
        AmReady_SI = 1'b1;
        @(negedge Clk_CI);
        AmReady_SI = 1'b0;
        #1;
        if (AmReady_SO !== 1'b1 || AmValid_SO !== 1'b0) bad++;
        repeat (amDelay) begin
            if (RspValid_SO !== 1'b0 || ReqReady_SO !== '0) bad++;
            @(negedge Clk_CI); #1;
        end
        AmValid_SI = 1'b1;
        AmLabel_A_DI = la; AmLabel_V_DI = lv;
        AmDistance_A_DI = da; AmDistance_V_DI = dv;
        @(negedge Clk_CI);
        AmValid_SI = 1'b0;
        randomizeAmBus();
        #1;
        if (RspValid_SO !== 1'b1 || AmReady_SO !== 1'b0) bad++;
        gotId = int'(RspId_DO);
        ola = RspLabel_A_DO; olv = RspLabel_V_DO;
        oda = RspDistance_A_DO; odv = RspDistance_V_DO;
        repeat (rspStall) begin
            @(negedge Clk_CI); #1;
            if (RspValid_SO !== 1'b1 || ReqReady_SO !== '0) bad++;
            if (RspLabel_A_DO !== ola || RspLabel_V_DO !== olv) bad++;
            if (RspDistance_A_DO !== oda || RspDistance_V_DO !== odv) bad++;
            if (int'(RspId_DO) != gotId) bad++;
        end
        ReqValid_SI = '0;
        RspReady_SI = 1'b1;
        @(negedge Clk_CI);
        RspReady_SI = 1'b0;
        #1;
        if (RspValid_SO !== 1'b0) bad++;
    endtask

    task automatic applyReset();
        @(negedge Clk_CI);
        Reset_RBI = 1'b0;
        ReqValid_SI = '0; AmReady_SI = 1'b0; AmValid_SI = 1'b0;
        RspReady_SI = 1'b0;
        @(negedge Clk_CI);
        Reset_RBI = 1'b1;
        modelPtr = 0;
    endtask

    task automatic test_reset();
        Reset_RBI = 1'b0;
        ReqValid_SI = '1;
        ReqHypervector_DI = rndHvs();
        AmReady_SI = 1'b0; AmValid_SI = 1'b0; RspReady_SI = 1'b0;
        randomizeAmBus();
        repeat (3) @(negedge Clk_CI);
        nCmp++;
        if ({ReqReady_SO, AmValid_SO, AmReady_SO, RspValid_SO} !== '0) begin
            nBad++;
            $display("FAIL reset_ctrl got %b want 0",
                     {ReqReady_SO, AmValid_SO, AmReady_SO, RspValid_SO});
        end
        nCmp++;
        if ({RspId_DO, RspLabel_A_DO, RspLabel_V_DO, RspDistance_A_DO,
             RspDistance_V_DO, AmHypervector_DO} !== '0) begin
            nBad++;
            $display("FAIL reset_data got id=%0d la=%0d da=%0d hv=%h want 0",
                     RspId_DO, RspLabel_A_DO, RspDistance_A_DO, AmHypervector_DO);
        end
        ReqValid_SI = '0;
        @(negedge Clk_CI);
        Reset_RBI = 1'b1;
        @(negedge Clk_CI); #1;
        nCmp++;
        if (ReqReady_SO !== '0 || AmValid_SO !== 1'b0) begin
            nBad++;
            $display("FAIL idle_after_reset got ready=%b amv=%b want 0",
                     ReqReady_SO, AmValid_SO);
        end
        modelPtr = 0;
    endtask

    task automatic test_single();
        int id, bad;
        logic [NR-1:0] r;
        logic [HV-1:0] h;
        logic [LW-1:0] a, v;
        logic [DW-1:0] da, dv;
        logic [NR*HV-1:0] hvs;
        hvs = {32'($urandom), 32'hA5A5A5A5, 32'($urandom)};
        runQuery(3'b010, hvs, 0, 5, 0, 4'd2, 4'd9, 8'd17, 8'd33,
                 id, r, h, a, v, da, dv, bad);
        nCmp++;
        if (id != 1 || r !== 3'b010) begin
            nBad++;
            $display("FAIL single_grant got id=%0d ready=%b want 1/010", id, r);
        end
        nCmp++;
        if (h !== 32'hA5A5A5A5) begin
            nBad++;
            $display("FAIL single_hv got %h want a5a5a5a5", h);
        end
        nCmp++;
        if (a !== 4'd2 || da !== 8'd17 || v !== 4'd9 || dv !== 8'd33) begin
            nBad++;
            $display("FAIL single_result got %0d/%0d/%0d/%0d want 2/9/17/33",
                     a, v, da, dv);
        end
        nCmp++;
        if (bad != 0) begin
            nBad++;
            $display("FAIL single_protocol got %0d violations want 0", bad);
        end
        modelPtr = 2;
        runQuery(3'b111, rndHvs(), 0, 0, 0, 4'd1, 4'd1, 8'd1, 8'd1,
                 id, r, h, a, v, da, dv, bad);
        nCmp++;
        if (id != 2 || bad != 0) begin
            nBad++;
            $display("FAIL single_ptr got id=%0d bad=%0d want 2/0", id, bad);
        end
        modelPtr = 0;
    endtask

    task automatic test_wrap_skip();
        int id, bad;
        logic [NR-1:0] r;
        logic [HV-1:0] h;
        logic [LW-1:0] a, v;
        logic [DW-1:0] da, dv;
        logic [NR-1:0] masks [3];
        int exp;
        masks[0] = 3'b010; masks[1] = 3'b001; masks[2] = 3'b101;
        for (int i = 0; i < 3; i++) begin
            exp = expGrant(masks[i], modelPtr);
            runQuery(masks[i], rndHvs(), 1, 1, 1, 4'd3, 4'd4, 8'd5, 8'd6,
                     id, r, h, a, v, da, dv, bad);
            nCmp++;
            if (id != exp || bad != 0) begin
                nBad++;
                $display("FAIL wrap_skip%0d got id=%0d bad=%0d want %0d/0",
                         i, id, bad, exp);
            end
            modelPtr = (exp + 1) % NR;
        end
    endtask

    task automatic test_fairness();
        int id, bad;
        logic [NR-1:0] r;
        logic [HV-1:0] h;
        logic [LW-1:0] a, v;
        logic [DW-1:0] da, dv;
        applyReset();
        for (int t = 0; t < 6; t++) begin
            runQuery(3'b111, rndHvs(), 0, $urandom_range(0, 2), 0,
                     4'd0, 4'd0, 8'd0, 8'd0, id, r, h, a, v, da, dv, bad);
            nCmp++;
            if (id != t % NR || r !== NR'(1 << (t % NR)) || bad != 0) begin
                nBad++;
                $display("FAIL fair%0d got id=%0d ready=%b bad=%0d want %0d",
                         t, id, r, bad, t % NR);
            end
        end
        modelPtr = 0;
    endtask

    task automatic test_backpressure();
        int id, bad, exp;
        logic [NR-1:0] r;
        logic [HV-1:0] h;
        logic [LW-1:0] a, v;
        logic [DW-1:0] da, dv;
        logic [NR*HV-1:0] hvs;
        hvs = rndHvs();
        exp = expGrant(3'b110, modelPtr);
        runQuery(3'b110, hvs, 4, 2, 3, 4'd7, 4'd8, 8'd200, 8'd99,
                 id, r, h, a, v, da, dv, bad);
        nCmp++;
        if (bad != 0) begin
            nBad++;
            $display("FAIL bp_stable got %0d violations want 0", bad);
        end
        nCmp++;
        if (id != exp || h !== hvs[exp*HV +: HV] || a !== 4'd7 || dv !== 8'd99) begin
            nBad++;
            $display("FAIL bp_data got id=%0d hv=%h la=%0d dv=%0d want %0d",
                     id, h, a, dv, exp);
        end
        modelPtr = (exp + 1) % NR;
    endtask

    task automatic test_random();
        int id, bad, exp;
        logic [NR-1:0] r, m;
        logic [HV-1:0] h;
        logic [LW-1:0] a, v, ea, ev;
        logic [DW-1:0] da, dv, eda, edv;
        logic [NR*HV-1:0] hvs;
        for (int t = 0; t < 20; t++) begin
            m = NR'($urandom_range(1, 7));
            hvs = rndHvs();
            ea = LW'($urandom); ev = LW'($urandom);
            eda = DW'($urandom); edv = DW'($urandom);
            exp = expGrant(m, modelPtr);
            runQuery(m, hvs, $urandom_range(0, 3), $urandom_range(0, 4),
                     $urandom_range(0, 3), ea, ev, eda, edv,
                     id, r, h, a, v, da, dv, bad);
            nCmp++;
            if (id != exp || r !== NR'(1 << exp) || h !== hvs[exp*HV +: HV]) begin
                nBad++;
                $display("FAIL rand%0d_grant got id=%0d ready=%b want %0d m=%b",
                         t, id, r, exp, m);
            end
            nCmp++;
            if (a !== ea || v !== ev || da !== eda || dv !== edv || bad != 0) begin
                nBad++;
                $display("FAIL rand%0d_rsp got %0d/%0d/%0d/%0d bad=%0d want %0d/%0d/%0d/%0d",
                         t, a, v, da, dv, bad, ea, ev, eda, edv);
            end
            modelPtr = (exp + 1) % NR;
        end
    endtask

    task automatic test_reset_midop();
        int id, bad, n;
        logic [NR-1:0] r;
        logic [HV-1:0] h;
        logic [LW-1:0] a, v;
        logic [DW-1:0] da, dv;
        runQuery(3'b010, rndHvs(), 0, 0, 0, 4'd5, 4'd5, 8'd5, 8'd5,
                 id, r, h, a, v, da, dv, bad);
        @(negedge Clk_CI);
        ReqValid_SI = 3'b100;
        ReqHypervector_DI = rndHvs();
        #1;
        n = 0;
        while (ReqReady_SO == '0 && n < 20) begin
            @(negedge Clk_CI); #1; n++;
        end
        @(negedge Clk_CI);
        ReqValid_SI = '1;
        AmReady_SI = 1'b1;
        @(negedge Clk_CI);
        AmReady_SI = 1'b0;
        #1;
        nCmp++;
        if (AmReady_SO !== 1'b1) begin
            nBad++;
            $display("FAIL midop_wait got amready=%b want 1", AmReady_SO);
        end
        #1;
        Reset_RBI = 1'b0;
        #1;
        nCmp++;
        if ({ReqReady_SO, AmValid_SO, AmReady_SO, RspValid_SO} !== '0 ||
            AmHypervector_DO !== '0 || RspId_DO !== '0) begin
            nBad++;
            $display("FAIL midop_async got ctl=%b hv=%h id=%0d want 0",
                     {ReqReady_SO, AmValid_SO, AmReady_SO, RspValid_SO},
                     AmHypervector_DO, RspId_DO);
        end
        ReqValid_SI = '0;
        @(negedge Clk_CI);
        Reset_RBI = 1'b1;
        modelPtr = 0;
        runQuery(3'b111, rndHvs(), 0, 1, 0, 4'd1, 4'd2, 8'd3, 8'd4,
                 id, r, h, a, v, da, dv, bad);
        nCmp++;
        if (id != 0 || bad != 0) begin
            nBad++;
            $display("FAIL midop_ptr got id=%0d bad=%0d want 0/0", id, bad);
        end
        modelPtr = 1;
    endtask

`ifdef AM_QUERY_SCHEDULER_TIMEOUT_EN
    task automatic test_timeout();
        int n, exp;
        exp = expGrant(3'b001, modelPtr);
        @(negedge Clk_CI);
        ReqValid_SI = 3'b001;
        #1;
        n = 0;
        while (ReqReady_SO == '0 && n < 20) begin
            @(negedge Clk_CI); #1; n++;
        end
        @(negedge Clk_CI);
        ReqValid_SI = '0;
        AmReady_SI = 1'b1;
        @(negedge Clk_CI);
        AmReady_SI = 1'b0;
        n = 0;
        while (RspValid_SO !== 1'b1 && n < 200) begin
            @(negedge Clk_CI); n++;
        end
        nCmp++;
        if (n != 9) begin
            nBad++;
            $display("FAIL timeout_latency got %0d cycles want 9", n);
        end
        nCmp++;
        if (RspTimeout_SO !== 1'b1 || RspLabel_A_DO !== '0 ||
            RspDistance_A_DO !== '0 || int'(RspId_DO) != exp) begin
            nBad++;
            $display("FAIL timeout_rsp got to=%b la=%0d da=%0d id=%0d want 1/0/0/%0d",
                     RspTimeout_SO, RspLabel_A_DO, RspDistance_A_DO, RspId_DO, exp);
        end
        RspReady_SI = 1'b1;
        @(negedge Clk_CI);
        RspReady_SI = 1'b0;
        modelPtr = (exp + 1) % NR;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_wrap_skip();
        test_fairness();
        test_backpressure();
        test_random();
        test_reset_midop();
`ifdef AM_QUERY_SCHEDULER_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/am_query_scheduler.md
Name: am_query_scheduler

Overview:
- Shares one associative_memory instance between NUM_REQ query sources, such as per-modality encoders or a training/inference path.
- Grants one requester at a time in round-robin order and forwards its query hypervector to the AM over the AM's valid/ready handshake.
- Captures the AM's A/V labels and distances and returns them with the requester ID on a single response channel.
- Sits between the encoder stage and the associative memory; exactly one query is in flight at any time.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ID_WIDTH, `ceilLog2(NUM_REQ), requester ID width (minimum 1).
- HV_DIM, `HV_DIMENSION, query hypervector width.
- TIMEOUT_CYCLES, 64, watchdog limit while waiting on the AM (used only with the optional feature).

Ports:
- Clk_CI  in  1  clock.
- Reset_RBI  in  1  asynchronous active-low reset.
- ReqValid_SI  in  NUM_REQ  per-requester query valid.
- ReqReady_SO  out  NUM_REQ  per-requester ready; one-hot or zero.
- ReqHypervector_DI  in  NUM_REQ*HV_DIM  packed queries; requester i occupies slice [i*HV_DIM +: HV_DIM].
- AmValid_SO  out  1  to AM ValidIn.
- AmReady_SI  in  1  from AM ReadyOut.
- AmHypervector_DO  out  HV_DIM  to AM HypervectorIn.
- AmValid_SI  in  1  from AM ValidOut.
- AmReady_SO  out  1  to AM ReadyIn.
- AmLabel_A_DI, AmLabel_V_DI  in  `LABEL_WIDTH  AM labels.
- AmDistance_A_DI, AmDistance_V_DI  in  `DISTANCE_WIDTH  AM distances.
- RspValid_SO  out  1  response valid.
- RspReady_SI  in  1  response ready.
- RspId_DO  out  ID_WIDTH  requester that issued the query.
- RspLabel_A_DO, RspLabel_V_DO  out  `LABEL_WIDTH  returned labels.
- RspDistance_A_DO, RspDistance_V_DO  out  `DISTANCE_WIDTH  returned distances.

Behaviour:
- Clock and reset: one clock, Clk_CI. Reset_RBI is asynchronous and active-low.
- Reset values (asserted at any time, including mid-transaction):
  - state = ARB, round-robin pointer = 0.
  - All *Valid_SO, ReqReady_SO and AmReady_SO = 0.
  - All data registers and Rsp* outputs = 0.
  - An in-flight query is abandoned; the AM must be reset in the same domain.
- FSM states: ARB, ISSUE, WAIT_AM, RESPOND.
- ARB:
  - Grant goes to the first i with ReqValid_SI[i]=1, searching from the pointer upward with modulo-NUM_REQ wrap.
  - ReqReady_SO[grant]=1 combinationally; all other ReqReady_SO bits are 0.
  - On the handshake: latch that requester's slice into the query register and the grant into the ID register, then go to ISSUE.
  - With no requester valid: stay in ARB; all ReqReady_SO = 0.
- ISSUE:
  - AmValid_SO=1 and AmHypervector_DO = query register, held stable.
  - On AmReady_SI=1 go to WAIT_AM; otherwise hold.
- WAIT_AM:
  - AmReady_SO=1.
  - On AmValid_SI=1 latch the four AM result buses, then go to RESPOND.
- RESPOND:
  - RspValid_SO=1; Rsp* outputs are registered and stable until accepted.
  - On RspReady_SI=1: pointer = (ID+1) mod NUM_REQ (explicit wrap when NUM_REQ is not a power of two), then go to ARB.
- AmValid_SI outside WAIT_AM is ignored (AmReady_SO=0). AmReady_SI outside ISSUE is ignored.
- Minimum latency from request handshake to RspValid_SO = 2 cycles plus AM compute time. Back-to-back grants are possible one cycle after the response handshake.
- Fairness: each continuously-valid requester is served within NUM_REQ transactions.
- A requester that deasserts valid before its grant loses nothing; no state is kept for it.
- RspReady_SI held low stalls the scheduler indefinitely; requesters see ReqReady_SO=0 throughout.

Optional Feature:
- Macro: AM_QUERY_SCHEDULER_TIMEOUT_EN.
- Defined:
  - Adds output RspTimeout_SO (1 bit, reset 0) and a cycle counter cleared on entry to WAIT_AM.
  - If the counter reaches TIMEOUT_CYCLES while in WAIT_AM: go to RESPOND with RspTimeout_SO=1, Rsp label/distance = 0, RspId_DO valid.
  - Afterwards the scheduler holds AmReady_SO=0 until AmValid_SI is next seen low, so a late result is not consumed as the next query's answer.
  - RspTimeout_SO=0 on normal completion.
- Undefined: no counter and no port; WAIT_AM waits forever.

Decomposition:
- Shared package/header const.vh holds:
  - `HV_DIMENSION, `LABEL_WIDTH, `DISTANCE_WIDTH, `ceilLog2.
  - New state encodings SCHED_ARB=2'd0, SCHED_ISSUE=2'd1, SCHED_WAIT=2'd2, SCHED_RESP=2'd3.
- Natural sub-module: rr_arbiter. It takes NUM_REQ request bits and the pointer, and returns a one-hot grant, a binary grant ID and an any-valid flag; it is purely combinational.

Test Plan:
- Single request: ReqValid_SI=3'b010 with HV=0xA5 pattern, AM model returns label_A=2, dist_A=17 after 5 cycles -> one RspValid_SO with RspId_DO=1, RspLabel_A_DO=2, RspDistance_A_DO=17; pointer=2.
- Fairness: all 3 requesters held valid for 6 transactions from reset -> grant order 0,1,2,0,1,2; ReqReady_SO always one-hot.
- Backpressure: AmReady_SI low for 4 cycles in ISSUE and RspReady_SI low for 3 cycles in RESPOND -> AmHypervector_DO and Rsp* stable throughout; no ReqReady_SO asserted.
- Wrap and skip: pointer=2 with ReqValid_SI=3'b001 -> grant 0; then pointer=1 with ReqValid_SI=3'b101 -> grant 2.
- Reset mid-op: drop Reset_RBI during WAIT_AM -> outputs zero immediately (asynchronously); after release, next request is granted from pointer 0.
- AM_QUERY_SCHEDULER_TIMEOUT_EN with TIMEOUT_CYCLES=8 and AM never valid -> RspValid_SO with RspTimeout_SO=1 nine cycles after entering WAIT_AM.
